decoder_itable_sequencer: RTL
=============================

DECODER_ITABLE_SEQUENCER -- requirements
Module: decoder_itable_sequencer

Interface
REQ-001 The block SHALL use one clock and asynchronous active-low reset: CLK and notRESET.
REQ-002 CLK  in  1  system clock; all state changes on rising edge.
REQ-003 notRESET  in  1  asynchronous, active-low reset.
REQ-004 Stall  in  1  holds the machine cycle in phase PR while 1.
REQ-005 Opcode_Valid  in  1  fetch handshake: Opcode bus is valid this PR phase.
REQ-006 Opcode  in  8  instruction byte from memory.
REQ-007 Set_ITABLE  in  8  OR-mask of all decoder P2_Set_* step lines, one bit per ITABLE bit.
REQ-008 Reset_ITABLE  in  1  OR of all decoder P2_Reset_ITABLE lines; ends the instruction.
REQ-009 ITABLE  out  8  micro-step register to the instruction decoders.
REQ-010 notITABLE  out  8  bitwise complement of ITABLE, always consistent with ITABLE.
REQ-011 IR  out  8  latched opcode; drives instruction-group decoder selection.
REQ-012 Phase_P2 / Phase_PA / Phase_PR  out  1 each  one-hot machine-cycle phase.
REQ-013 Enable  out  1  decoder enable; 1 only in EXEC state.
REQ-014 Fetch_Req  out  1  1 in FETCH state; requests an opcode from memory.

Function
REQ-015 The phase counter SHALL sequence P2 -> PA -> PR -> P2, one phase per CLK, exactly one phase output high at all times.
REQ-016 While in PR with Stall=1, the phase SHALL remain PR; Stall SHALL be ignored in P2 and PA.
REQ-017 The FSM SHALL have two states, FETCH and EXEC; Enable = (state==EXEC), Fetch_Req = (state==FETCH).
REQ-018 FETCH: on the PR->P2 edge with Opcode_Valid=1 and Stall=0, IR <= Opcode, ITABLE <= 0x00, state <= EXEC.
REQ-019 FETCH: on the PR->P2 edge with Opcode_Valid=0, the block SHALL stay in FETCH, with IR and ITABLE unchanged, and repeat the cycle.
REQ-020 EXEC: Set_ITABLE and Reset_ITABLE SHALL be sampled only on the P2->PA edge; they SHALL be ignored in other phases and in FETCH.
REQ-021 EXEC, P2->PA edge, Reset_ITABLE=1: ITABLE <= 0x00 and state <= FETCH at that same edge; Enable SHALL fall in PA.
REQ-022 EXEC, P2->PA edge, Reset_ITABLE=0: ITABLE <= ITABLE | Set_ITABLE (bits only set, never cleared).
REQ-023 Simultaneous Reset_ITABLE=1 and Set_ITABLE!=0: reset SHALL win; ITABLE=0x00.
REQ-024 Set_ITABLE=0 and Reset_ITABLE=0 in an EXEC P2: ITABLE SHALL hold; the next machine cycle re-executes the same step.
REQ-025 ITABLE=0xFF with further sets SHALL saturate at 0xFF; there is no wrap.
REQ-026 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.
REQ-027 Opcode_Valid is a single-phase handshake; Opcode_Valid asserted outside FETCH PR SHALL have no effect.

Reset
REQ-028 notRESET=0 SHALL immediately force: phase P2 and state FETCH. Outputs take these values:
- ITABLE=0x00, notITABLE=0xFF, IR=0x00
- Phase_P2=1, Phase_PA=0, Phase_PR=0
- Enable=0, Fetch_Req=1
REQ-029 Reset asserted mid-cycle or mid-instruction SHALL abort it with no partial ITABLE/IR update.
REQ-030 After notRESET rises, the first CLK edge SHALL advance P2->PA.

Verification
REQ-031 Reset, then Opcode=0xC3 with Opcode_Valid=1 in first PR -> IR=0xC3, EXEC, ITABLE=0x00, Enable=1 at next P2.
REQ-032 JP nn flow: EXEC P2 with Set_ITABLE=0x01 -> ITABLE=0x01. Next P2 with Reset_ITABLE=1 -> ITABLE=0x00, FETCH, Fetch_Req=1.
REQ-033 Stall=1 for 3 clocks in PR -> Phase_PR stays 1 for 4 clocks total, and ITABLE/IR are unchanged.
REQ-034 Simultaneous Set_ITABLE=0x06 with Reset_ITABLE=1 in P2 -> ITABLE=0x00, notITABLE=0xFF, FETCH.
REQ-035 FETCH with Opcode_Valid=0 for two cycles, then 1 with Opcode=0x3E -> two repeated FETCH cycles, then IR=0x3E.
REQ-036 notRESET pulsed low during EXEC PA with ITABLE=0x05 -> all outputs at reset values asynchronously, with no clock edge required.

Source files
------------

// File: rtl/decoder_itable_sequencer.sv
// Machine-cycle sequencer for the instruction decoders.
// A one-hot phase counter steps P2 -> PA -> PR. A two-state FETCH/EXEC FSM
// latches the opcode into IR at the end of a fetch cycle. In EXEC it
// accumulates decoder step requests into ITABLE at every P2.
module decoder_itable_sequencer (
    input  logic       CLK,
    input  logic       notRESET,
    input  logic       Stall,
    input  logic       Opcode_Valid,
    input  logic [7:0] Opcode,
    input  logic [7:0] Set_ITABLE,
    input  logic       Reset_ITABLE,
    output logic [7:0] ITABLE,
    output logic [7:0] notITABLE,
    output logic [7:0] IR,
    output logic       Phase_P2,
    output logic       Phase_PA,
    output logic       Phase_PR,
    output logic       Enable,
    output logic       Fetch_Req
);

    // The phase is encoded one-hot so each phase output is a single register bit.
    typedef enum logic [2:0] {
        PH_P2 = 3'b001,
        PH_PA = 3'b010,
        PH_PR = 3'b100
    } phase_e;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_e;

    phase_e     phase_q, phase_d;
    state_e     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] itable_q, itable_d;

    // cycle_end: this edge takes PR -> P2. Stall holds PR and so blocks it.
    // step_edge: this edge takes P2 -> PA. That is the only point where decoder step lines count.
    logic cycle_end;
    logic step_edge;

    assign cycle_end = (phase_q == PH_PR) && !Stall;
    assign step_edge = (phase_q == PH_P2);

    // State register: reset aborts any cycle in flight, with no partial update.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            phase_q  <= PH_P2;
            state_q  <= ST_FETCH;
            ir_q     <= 8'h00;
            itable_q <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments make every register update from the pre-edge values.
            phase_q  <= phase_d;
            state_q  <= state_d;
            ir_q     <= ir_d;
            itable_q <= itable_d;
        end
    end

    // Next-state logic for the phase counter, the FSM and the IR/ITABLE datapath.
    always_comb begin
        // NOTE: hold values are assigned first so that no path leaves a signal unassigned, which would infer a latch.
        phase_d  = phase_q;
        state_d  = state_q;
        ir_d     = ir_q;
        itable_d = itable_q;

        case (phase_q)
            PH_P2:   phase_d = PH_PA;
            PH_PA:   phase_d = PH_PR;
            PH_PR:   phase_d = Stall ? PH_PR : PH_P2;
            default: phase_d = PH_P2;
        endcase

        case (state_q)
            ST_FETCH: begin
                if (cycle_end && Opcode_Valid) begin
                    ir_d     = Opcode;
                    itable_d = 8'h00;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (step_edge) begin
                    if (Reset_ITABLE) begin
                        // End of instruction. This takes priority over any step set in the same P2.
                        itable_d = 8'h00;
                        state_d  = ST_FETCH;
                    end else begin
                        // Steps only accumulate, so an all-ones ITABLE saturates rather than wraps.
                        itable_d = itable_q | Set_ITABLE;
                    end
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Output decode: every output comes from registered state, never straight from an input.
    always_comb begin
        ITABLE    = itable_q;
        notITABLE = ~itable_q;
        IR        = ir_q;
        Phase_P2  = (phase_q == PH_P2);
        Phase_PA  = (phase_q == PH_PA);
        Phase_PR  = (phase_q == PH_PR);
        Enable    = (state_q == ST_EXEC);
        Fetch_Req = (state_q == ST_FETCH);
    end

endmodule
